// File: rtl/cruise_cntl.sv
// cruise_cntl -- cruise-control supervisor.
// Arbitrates driver pedals and cruise buttons, then drives accelerate/brake
// commands to the speed controller. Automatic correction is a single-cycle
// pulse followed by a DWELL-cycle settle window.
//
// Ports:
//   clock                   system clock, rising edge
//   reset_n                 asynchronous active-low reset
//   keys                    ignition; 0 forces OFF
//   drv_brake, drv_accel    driver pedal requests
//   cc_set, cc_cancel       cruise buttons (level-sampled)
//   cc_up, cc_down          cruise set-speed adjust buttons (level-sampled)
//   speed[1:0]              current speed: 0 STOP, 1 LOW, 2 MEDIUM, 3 HIGH
//   accelerate, brake       registered commands to the speed controller
//   cc_active               high in CRUISE or SETTLE
//   target[1:0]             registered cruise set-speed
module cruise_cntl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       keys,
  input  logic       drv_brake,
  input  logic       drv_accel,
  input  logic       cc_set,
  input  logic       cc_cancel,
  input  logic       cc_up,
  input  logic       cc_down,
  input  logic [1:0] speed,
  output logic       accelerate,
  output logic       brake,
  output logic       cc_active,
  output logic [1:0] target
);

  typedef enum logic [1:0] {OFF, MANUAL, CRUISE, SETTLE} state_t;

  localparam logic [3:0] DWELL_CNT = 4'(DWELL);

  state_t     state;
  logic [3:0] count;
  logic       adjust;

  // Any set-speed button press claims the cycle, even if up and down cancel.
  assign adjust = cc_up | cc_down;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= OFF;
      accelerate <= 1'b0;
      brake      <= 1'b0;
      cc_active  <= 1'b0;
      target     <= '0;
      count      <= '0;
    end else begin
      // Commands default to idle; every branch below only raises them.
      accelerate <= 1'b0;
      brake      <= 1'b0;
      if (!keys) begin
        state     <= OFF;
        cc_active <= 1'b0;
        target    <= '0;
        count     <= '0;
      end else begin
        case (state)
          OFF: begin
            state     <= MANUAL;
            cc_active <= 1'b0;
          end
          MANUAL: begin
            if (cc_set && !drv_brake && speed != 2'd0) begin
              state     <= CRUISE;
              cc_active <= 1'b1;
              target    <= speed;
            end else begin
              brake      <= drv_brake;
              accelerate <= drv_accel & ~drv_brake;
            end
          end
          CRUISE, SETTLE: begin
            if (drv_brake) begin
              state     <= MANUAL;
              cc_active <= 1'b0;
              brake     <= 1'b1;
              count     <= '0;
            end else if (cc_cancel) begin
              state     <= MANUAL;
              cc_active <= 1'b0;
              count     <= '0;
            end else if (cc_set) begin
              state     <= CRUISE;
              cc_active <= 1'b1;
              count     <= '0;
              if (speed != 2'd0) target <= speed;
            end else begin
              cc_active <= 1'b1;
              if (cc_up && !cc_down && target != 2'd3)
                target <= target + 2'd1;
              else if (cc_down && !cc_up && target > 2'd1)
                target <= target - 2'd1;

              if (state == SETTLE) begin
                // Settle window runs regardless of buttons; pedal passes through.
                accelerate <= drv_accel & ~adjust;
                if (count <= 4'd1) begin
                  state <= CRUISE;
                  count <= '0;
                end else begin
                  count <= count - 4'd1;
                end
              end else if (adjust) begin
                // Button cycle: no command, no correction.
              end else if (drv_accel) begin
                accelerate <= 1'b1;
              end else if (speed < target) begin
                accelerate <= 1'b1;
                count      <= DWELL_CNT;
                state      <= SETTLE;
              end else if (speed > target) begin
                brake <= 1'b1;
                count <= DWELL_CNT;
                state <= SETTLE;
              end
            end
          end
          default: begin
            state     <= OFF;
            cc_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cruise_cntl.sv
// Directed-vector bench for cruise_cntl with a scoreboard: the stimulus
// process pushes the hand-computed expected outputs for each cycle, and a
// monitor pops and compares them one time unit after each rising edge.
module tb_cruise_cntl;

  logic       clock;
  logic       reset_n;
  logic       keys, drv_brake, drv_accel;
  logic       cc_set, cc_cancel, cc_up, cc_down;
  logic [1:0] speed;
  logic       accelerate, brake, cc_active;
  logic [1:0] target;

  typedef struct packed {
    logic       acc;
    logic       brk;
    logic       act;
    logic [1:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  cruise_cntl #(.DWELL(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .keys       (keys),
    .drv_brake  (drv_brake),
    .drv_accel  (drv_accel),
    .cc_set     (cc_set),
    .cc_cancel  (cc_cancel),
    .cc_up      (cc_up),
    .cc_down    (cc_down),
    .speed      (speed),
    .accelerate (accelerate),
    .brake      (brake),
    .cc_active  (cc_active),
    .target     (target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one scoreboard entry per clock edge while stimulus is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (accelerate === e.acc && brake === e.brk &&
            cc_active === e.act && target === e.tgt && !(accelerate && brake))
          n_pass++;
        else
          $display("FAIL cycle%0d acc/brk/act/tgt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                   n_checks, accelerate, brake, cc_active, target,
                   e.acc, e.brk, e.act, e.tgt);
      end
    end
  end

  // Push expectation for the edge following the current inputs.
  task automatic cyc(input logic ea, input logic eb, input logic ec, input logic [1:0] et);
    exp_t e;
    e.acc = ea; e.brk = eb; e.act = ec; e.tgt = et;
    q.push_back(e);
    step_no++;
    @(negedge clock);
  endtask

  task automatic btn_clear();
    drv_brake = 0; drv_accel = 0;
    cc_set = 0; cc_cancel = 0; cc_up = 0; cc_down = 0;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (accelerate === 1'b0 && brake === 1'b0 && cc_active === 1'b0 && target === 2'd0)
      n_pass++;
    else
      $display("FAIL %s acc/brk/act/tgt got %b/%b/%b/%0d want 0/0/0/0",
               name, accelerate, brake, cc_active, target);
  endtask

  initial begin
    reset_n = 0; keys = 0; speed = 2'd0;
    btn_clear();
    #3 check_zero("reset");
    @(negedge clock);
    reset_n = 1;

    // Manual driving
    keys = 1; drv_accel = 1;       cyc(0,0,0,0);  // OFF -> MANUAL, no command
    cyc(1,0,0,0);                                // MANUAL passes accel
    drv_brake = 1;                 cyc(0,1,0,0);  // brake wins
    btn_clear();                   cyc(0,0,0,0);
    cc_set = 1; speed = 2'd0;      cyc(0,0,0,0);  // set at STOP ignored

    // Engage and adjust target
    speed = 2'd1;                  cyc(0,0,1,1);
    cc_set = 0; cc_up = 1;         cyc(0,0,1,2);
    cyc(0,0,1,3);
    cyc(0,0,1,3);                                // saturate at 3
    cc_up = 0; cc_down = 1;        cyc(0,0,1,2);
    cyc(0,0,1,1);
    cyc(0,0,1,1);                                // saturate at 1
    cc_down = 0;                   cyc(0,0,1,1);  // speed == target, idle

    // Acceleration pulses with dwell
    cc_up = 1;                     cyc(0,0,1,2);
    cyc(0,0,1,3);
    cc_up = 0;                     cyc(1,0,1,3);  // pulse
    for (int i = 0; i < 4; i++)    cyc(0,0,1,3);  // settle
    cyc(1,0,1,3);                                // second pulse
    speed = 2'd3;
    for (int i = 0; i < 6; i++)    cyc(0,0,1,3);  // on target, no pulses

    // Driver accel override, then brake correction
    cc_down = 1;                   cyc(0,0,1,2);
    cyc(0,0,1,1);
    cc_down = 0; drv_accel = 1;    cyc(1,0,1,1);
    cyc(1,0,1,1);
    drv_accel = 0;                 cyc(0,1,1,1);  // brake pulse
    cyc(0,0,1,1);
    cyc(0,0,1,1);
    drv_brake = 1;                 cyc(0,1,0,1);  // brake mid-settle
    drv_brake = 0;                 cyc(0,0,0,1);  // target retained

    // Cancel has priority over driver accel
    speed = 2'd2; cc_set = 1;      cyc(0,0,1,2);
    cc_set = 0; cc_cancel = 1; drv_accel = 1; cyc(0,0,0,2);
    btn_clear();

    // Ignition off during settle
    cc_set = 1;                    cyc(0,0,1,2);
    cc_set = 0; speed = 2'd1;      cyc(1,0,1,2);  // pulse -> settle
    keys = 0;                      cyc(0,0,0,0);
    keys = 1;                      cyc(0,0,0,0);
    speed = 2'd2; cc_set = 1;      cyc(0,0,1,2);
    cc_set = 0;                    cyc(0,0,1,2);

    // Asynchronous reset between edges
    #2 reset_n = 0;
    #1 check_zero("async_reset");
    @(negedge clock);
    reset_n = 1;
    cyc(0,0,0,0);                                // OFF -> MANUAL
    cyc(0,0,0,0);                                // no re-engage without set

    @(negedge clock);
    @(negedge clock);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain queue got %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
